motors_ctrl: RTL
================

Name: motors_ctrl

Overview:
- Slave end of the motors control interface; consumes move commands from the processor, which is the interface master.
- Each accepted command first moves the pen servo if its position changes, then waits for the servo to settle.
- It then emits step/dir pulse trains for the X and Y steppers concurrently.
- It pulses done when the move completes and holds rdy high whenever it can accept a new trigger.

Parameters:
- PULSE_NUM_X_BITS, 16, width of pulse_num_x (signed two's complement).
- PULSE_NUM_Y_BITS, 16, width of pulse_num_y (signed two's complement).
- STEP_PERIOD_CYCLES, 1000, clk cycles per step period; must be ≥2.
- STEP_HIGH_CYCLES, 500, cycles out_step_* is high in each period; 1 ≤ value < STEP_PERIOD_CYCLES.
- SERVO_SETTLE_CYCLES, 100000, cycles spent waiting after a servo position change; must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pulse_num_x  in  PULSE_NUM_X_BITS  signed X step count; the sign gives direction
- pulse_num_y  in  PULSE_NUM_Y_BITS  signed Y step count; the sign gives direction
- servo_pos  in  1  requested pen position (0=up, 1=down)
- trigger  in  1  command strobe
- done  out  1  one-cycle pulse at end of a move
- rdy  out  1  high when a trigger will be accepted
- out_step_x  out  1  X stepper step pulse
- out_dir_x  out  1  X direction (1 = negative count)
- out_step_y  out  1  Y stepper step pulse
- out_dir_y  out  1  Y direction (1 = negative count)
- out_servo  out  1  servo position command to the servo PWM block

Behaviour:
- Interface contract: one clock; reset is asynchronous and active-low. Port names clk and reset.
- Reset values while reset=0:
  - State IDLE.
  - done=0, rdy=1.
  - out_step_x=0, out_step_y=0, out_dir_x=0, out_dir_y=0, out_servo=0.
  - All counters 0.
- States: IDLE, SERVO_WAIT, STEPPING, DONE.
- rdy=1 in IDLE and DONE, and 0 otherwise.
- Accept rule: a command is accepted on a rising clk edge where trigger=1 and rdy=1 (cycle T).
  - On acceptance, latch magnitudes |pulse_num_x| and |pulse_num_y| into counters one bit wider than the input, so the most-negative value has magnitude 2^(N-1) exactly.
  - Latch out_dir_x = sign bit of pulse_num_x and out_dir_y = sign bit of pulse_num_y.
  - A trigger with rdy=0 is ignored entirely; it is neither queued nor does it affect the current move.
- Next state on acceptance, evaluated from the inputs at T:
  - servo_pos != out_servo → SERVO_WAIT; out_servo takes servo_pos at T+1.
  - else any magnitude ≠ 0 → STEPPING.
  - else → DONE.
- SERVO_WAIT:
  - Lasts exactly SERVO_SETTLE_CYCLES cycles.
  - Then go to STEPPING if any magnitude ≠ 0, else to DONE.
- STEPPING:
  - A period counter runs 0..STEP_PERIOD_CYCLES-1 and wraps.
  - out_step_x is high for period counts 0..STEP_HIGH_CYCLES-1 while the X remaining count is > 0; out_step_y follows the same rule on its own count.
  - At the end of each period, every nonzero remaining count decrements by 1.
  - The state lasts max(|x|,|y|)·STEP_PERIOD_CYCLES cycles.
  - When both counts reach 0 at a period end, go to DONE; both step outputs are 0 from that cycle on.
  - The first out_step_* rising edge is in the first STEPPING cycle.
- DONE:
  - Lasts one cycle with done=1; done is 0 in every other state.
  - Goes to IDLE, or accepts a new trigger in the same cycle because rdy=1, so back-to-back commands have no idle gap.
- Direction outputs hold their latched values until the next accepted command. out_servo holds until changed by a command.
- Pure-zero command with unchanged servo: accept at T, done=1 during T+1.
- Reset mid-move: state returns to IDLE immediately and step outputs drop to 0 asynchronously. out_servo returns to 0 and no done pulse is generated.
- Inputs are sampled only at acceptance; changes to inputs during a move have no effect.

Test Plan (STEP_PERIOD_CYCLES=4, STEP_HIGH_CYCLES=2, SERVO_SETTLE_CYCLES=5):
- Reset, then release → rdy=1, done=0, all step/dir/servo outputs 0.
- Trigger x=3, y=-1, servo=0 → no servo wait; out_dir_x=0, out_dir_y=1.
  - Exactly 3 X pulses and 1 Y pulse, each 2 cycles high in a 4-cycle period.
  - done pulses 12 cycles after STEPPING entry; rdy=0 throughout the move.
- Trigger x=0, y=2, servo=1 from servo=0 → out_servo=1 at T+1; 5 wait cycles; then 2 Y pulses and 0 X pulses; done at T+1+5+8.
- Trigger x=0, y=0, servo unchanged → done=1 in cycle T+1, with no step pulses.
- Trigger x=-32768 with 16-bit width → out_dir_x=1 and exactly 32768 X pulses (bench counts them).
  - A second trigger asserted mid-move is ignored.
  - A trigger held during the DONE cycle is accepted, and the next move starts with no idle gap.
- Assert reset during STEPPING after 1 of 3 pulses → outputs return to reset values at once; no done; rdy=1 after release.

Source files
------------

// File: rtl/motors_ctrl.sv
// Motors control slave: takes one move command at a time, repositions the pen
// servo if needed, then drives concurrent X/Y step/dir pulse trains.
module motors_ctrl #(
    parameter int PULSE_NUM_X_BITS    = 16,
    parameter int PULSE_NUM_Y_BITS    = 16,
    parameter int STEP_PERIOD_CYCLES  = 1000,
    parameter int STEP_HIGH_CYCLES    = 500,
    parameter int SERVO_SETTLE_CYCLES = 100000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [PULSE_NUM_X_BITS-1:0] pulse_num_x,
    input  logic signed [PULSE_NUM_Y_BITS-1:0] pulse_num_y,
    input  logic                               servo_pos,
    input  logic                               trigger,
    output logic                               done,
    output logic                               rdy,
    output logic                               out_step_x,
    output logic                               out_dir_x,
    output logic                               out_step_y,
    output logic                               out_dir_y,
    output logic                               out_servo,
    output logic [1:0]                         dbg_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVO_WAIT = 2'd1,
        STEPPING   = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam int XW    = PULSE_NUM_X_BITS;
    localparam int YW    = PULSE_NUM_Y_BITS;
    localparam int PER_W = $clog2(STEP_PERIOD_CYCLES);
    localparam int SET_W = (SERVO_SETTLE_CYCLES > 1) ? $clog2(SERVO_SETTLE_CYCLES) : 1;

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(STEP_PERIOD_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_HIGH = PER_W'(STEP_HIGH_CYCLES);
    localparam logic [PER_W-1:0] PER_ONE  = 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SERVO_SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_ONE  = 1;
    localparam logic [XW:0]      X_ONE    = 1;
    localparam logic [YW:0]      Y_ONE    = 1;

    state_t           state_q, state_d, cmd_next;
    logic [PER_W-1:0] per_q;
    logic [SET_W-1:0] set_q;
    logic [XW:0]      cnt_x_q, ext_x, mag_x_in;
    logic [YW:0]      cnt_y_q, ext_y, mag_y_in;
    logic             dir_x_q, dir_y_q, servo_q;
    logic             accept, any_in, any_cnt, period_end, last_step;

    // Handshake: a command is taken on any rising edge where trigger and rdy
    // are both high; rdy depends only on state, and a trigger seen while rdy
    // is low is dropped, never queued.
    assign rdy    = (state_q == IDLE) || (state_q == DONE);
    assign done   = (state_q == DONE);
    assign accept = trigger && rdy;

    // Magnitudes are one bit wider so the most-negative input maps exactly.
    assign ext_x    = {pulse_num_x[XW-1], pulse_num_x};
    assign ext_y    = {pulse_num_y[YW-1], pulse_num_y};
    assign mag_x_in = pulse_num_x[XW-1] ? -ext_x : ext_x;
    assign mag_y_in = pulse_num_y[YW-1] ? -ext_y : ext_y;

    assign any_in     = (|mag_x_in) || (|mag_y_in);
    assign any_cnt    = (|cnt_x_q) || (|cnt_y_q);
    assign period_end = (per_q == PER_LAST);
    // Both remaining counts are at most one, so this period is the last.
    assign last_step  = period_end && (cnt_x_q[XW:1] == '0) && (cnt_y_q[YW:1] == '0);

    assign out_step_x = (state_q == STEPPING) && (per_q < PER_HIGH) && (|cnt_x_q);
    assign out_step_y = (state_q == STEPPING) && (per_q < PER_HIGH) && (|cnt_y_q);
    assign out_dir_x  = dir_x_q;
    assign out_dir_y  = dir_y_q;
    assign out_servo  = servo_q;
    assign dbg_state  = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_next = DONE;
        if (servo_pos != servo_q) begin
            cmd_next = SERVO_WAIT;
        end else if (any_in) begin
            cmd_next = STEPPING;
        end
        case (state_q)
            IDLE: begin
                if (accept) state_d = cmd_next;
            end
            SERVO_WAIT: begin
                if (set_q == SET_LAST) state_d = any_cnt ? STEPPING : DONE;
            end
            STEPPING: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                state_d = accept ? cmd_next : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_q   <= '0;
            set_q   <= '0;
            cnt_x_q <= '0;
            cnt_y_q <= '0;
            dir_x_q <= 1'b0;
            dir_y_q <= 1'b0;
            servo_q <= 1'b0;
        end else if (accept) begin
            per_q   <= '0;
            set_q   <= '0;
            cnt_x_q <= mag_x_in;
            cnt_y_q <= mag_y_in;
            dir_x_q <= pulse_num_x[XW-1];
            dir_y_q <= pulse_num_y[YW-1];
            servo_q <= servo_pos;
        end else begin
            case (state_q)
                SERVO_WAIT: begin
                    set_q <= set_q + SET_ONE;
                end
                STEPPING: begin
                    per_q <= period_end ? '0 : per_q + PER_ONE;
                    if (period_end) begin
                        if (|cnt_x_q) cnt_x_q <= cnt_x_q - X_ONE;
                        if (|cnt_y_q) cnt_y_q <= cnt_y_q - Y_ONE;
                    end
                end
                default: begin
                    per_q <= '0;
                    set_q <= '0;
                end
            endcase
        end
    end

endmodule
